// File: rtl/mac_array4.sv
// mac_array4: four-lane int8 multiply-accumulate engine.
//
// Each accepted beat carries four signed int8 activations (feature) and one
// packed weight word per lane. Stage 1 registers the per-lane 4-element dot
// product. Stage 2 adds that dot product into the lane accumulator one cycle
// later. After the programmed number of beats the four accumulators are
// presented under a result_valid / result_ack handshake.
//
// Build option:
//   MAC_ARRAY_SAT_EN  when defined, stage 2 saturates each lane to the signed
//                     ACC_W range. When undefined (default), addition wraps.
//
// Ports:
//   clk               rising-edge clock
//   rstn              synchronous active-low reset
//   start, len        run request (IDLE only) and beat count sampled with it
//   in_valid/in_ready beat handshake; in_ready is high only in RUN
//   feature           x0=[31:24] x1=[23:16] x2=[15:8] x3=[7:0], signed int8
//   weight0..weight3  per-lane signed int8 weights, same byte order
//   busy              high outside IDLE
//   result_valid      high in DONE
//   result_ack        consumer accepted the results
//   result0..result3  registered lane accumulators, signed ACC_W

module mac_array4 #(
  parameter int LEN_W = 9,
  parameter int ACC_W = 26
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    start,
  input  logic [LEN_W-1:0]        len,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [31:0]             feature,
  input  logic [31:0]             weight0,
  input  logic [31:0]             weight1,
  input  logic [31:0]             weight2,
  input  logic [31:0]             weight3,
  output logic                    busy,
  output logic                    result_valid,
  input  logic                    result_ack,
  output logic signed [ACC_W-1:0] result0,
  output logic signed [ACC_W-1:0] result1,
  output logic signed [ACC_W-1:0] result2,
  output logic signed [ACC_W-1:0] result3
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                  state_q;
  logic [LEN_W-1:0]        remaining_q;
  logic                    s1_valid_q;
  logic signed [17:0]      dot_q [4];
  logic signed [ACC_W-1:0] acc_q [4];
  logic [31:0]             weight_lane [4];

  always_comb begin
    weight_lane[0] = weight0;
    weight_lane[1] = weight1;
    weight_lane[2] = weight2;
    weight_lane[3] = weight3;
  end

  // Signed 4-element dot product; four 16-bit products fit in 18 bits.
  function automatic logic signed [17:0] lane_dot(input logic [31:0] x,
                                                  input logic [31:0] w);
    logic signed [17:0] s;
    logic signed [7:0]  a;
    logic signed [7:0]  b;
    logic signed [15:0] p;
    s = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      a = x[8*i +: 8];
      b = w[8*i +: 8];
      p = a * b;
      s = s + 18'(p);
    end
    return s;
  endfunction

  function automatic logic signed [ACC_W-1:0] acc_add(
      input logic signed [ACC_W-1:0] acc,
      input logic signed [17:0]      dot);
`ifdef MAC_ARRAY_SAT_EN
    logic signed [ACC_W:0] s;
    s = (ACC_W+1)'(acc) + (ACC_W+1)'(dot);
    // Top two bits disagree only when the sum left the ACC_W signed range.
    if (s[ACC_W] != s[ACC_W-1]) begin
      return s[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    end
    return s[ACC_W-1:0];
`else
    return acc + ACC_W'(dot);
`endif
  endfunction

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      s1_valid_q  <= 1'b0;
      for (int unsigned k = 0; k < 4; k++) begin
        dot_q[k] <= '0;
        acc_q[k] <= '0;
      end
    end else begin
      s1_valid_q <= 1'b0;

      // Stage 2 runs independently of the state so the final beat lands in DRAIN.
      if (s1_valid_q) begin
        for (int unsigned k = 0; k < 4; k++) begin
          acc_q[k] <= acc_add(acc_q[k], dot_q[k]);
        end
      end

      case (state_q)
        IDLE: begin
          if (start) begin
            for (int unsigned k = 0; k < 4; k++) begin
              acc_q[k] <= '0;
            end
            remaining_q <= len;
            state_q     <= (len == '0) ? DONE : RUN;
          end
        end
        RUN: begin
          if (in_valid) begin
            s1_valid_q <= 1'b1;
            for (int unsigned k = 0; k < 4; k++) begin
              dot_q[k] <= lane_dot(feature, weight_lane[k]);
            end
            remaining_q <= remaining_q - LEN_W'(1);
            if (remaining_q == LEN_W'(1)) begin
              state_q <= DRAIN;
            end
          end
        end
        DRAIN: begin
          state_q <= DONE;
        end
        DONE: begin
          if (result_ack) begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  always_comb begin
    in_ready     = (state_q == RUN);
    busy         = (state_q != IDLE);
    result_valid = (state_q == DONE);
  end

  assign result0 = acc_q[0];
  assign result1 = acc_q[1];
  assign result2 = acc_q[2];
  assign result3 = acc_q[3];

endmodule

// File: tb/tb_mac_array4.sv
module tb_mac_array4;

  logic              clk = 1'b0;
  logic              rstn;
  logic              start;
  logic [8:0]        len;
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       feature;
  logic [31:0]       w [4];
  logic              busy;
  logic              result_valid;
  logic              result_ack;
  logic signed [25:0] res [4];

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference: per-lane running sums, updated whenever a beat handshake occurs.
  longint macc [4];
  int     beats;

  mac_array4 #(.LEN_W(9), .ACC_W(26)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .start        (start),
    .len          (len),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .feature      (feature),
    .weight0      (w[0]),
    .weight1      (w[1]),
    .weight2      (w[2]),
    .weight3      (w[3]),
    .busy         (busy),
    .result_valid (result_valid),
    .result_ack   (result_ack),
    .result0      (res[0]),
    .result1      (res[1]),
    .result2      (res[2]),
    .result3      (res[3])
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic longint dot4(input logic [31:0] x, input logic [31:0] wt);
    longint s;
    logic signed [7:0] a;
    logic signed [7:0] b;
    longint la;
    longint lb;
    s = 0;
    for (int i = 0; i < 4; i++) begin
      a  = x[31-8*i -: 8];
      b  = wt[31-8*i -: 8];
      la = a;
      lb = b;
      s += la * lb;
    end
    return s;
  endfunction

  function automatic longint model_add(input longint acc, input longint d);
    longint v;
    v = acc + d;
`ifdef MAC_ARRAY_SAT_EN
    if (v > 33554431)  v = 33554431;
    if (v < -33554432) v = -33554432;
`endif
    return v;
  endfunction

  function automatic longint wrap26(input longint v);
    logic signed [25:0] t;
    t = 26'(v);
    return t;
  endfunction

  task automatic model_clear;
    for (int k = 0; k < 4; k++) macc[k] = 0;
    beats = 0;
  endtask

  // One clock: record a handshake for the model, then compare at the falling edge.
  task automatic step;
    logic acc_now;
    acc_now = rstn && in_valid && in_ready;
    @(posedge clk);
    if (acc_now) begin
      beats++;
      for (int k = 0; k < 4; k++) macc[k] = model_add(macc[k], dot4(feature, w[k]));
    end
    @(negedge clk);
    if (rstn && result_valid) begin
      for (int k = 0; k < 4; k++) begin
        check($sformatf("result%0d_vs_model", k), res[k], wrap26(macc[k]));
      end
    end
  endtask

  task automatic do_start(input int l);
    start = 1'b1;
    len   = 9'(l);
    model_clear();
    step();
    start = 1'b0;
  endtask

  task automatic set_beat(input logic [31:0] f, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] c, input logic [31:0] d);
    feature = f; w[0] = a; w[1] = b; w[2] = c; w[3] = d;
  endtask

  task automatic wait_rv(input int max_cycles);
    for (int i = 0; i < max_cycles && !result_valid; i++) step();
    check("result_valid_within_bound", result_valid, 1);
  endtask

  task automatic do_ack;
    result_ack = 1'b1;
    step();
    result_ack = 1'b0;
    check("idle_after_ack_busy", busy, 0);
    check("idle_after_ack_rv", result_valid, 0);
  endtask

  logic [31:0] tab_f [3];
  logic [31:0] tab_w [3][4];
  int pattern [5];

  initial begin
    rstn = 1'b0; start = 1'b0; len = '0; in_valid = 1'b0; result_ack = 1'b0;
    set_beat('0, '0, '0, '0, '0);
    model_clear();
    @(negedge clk);
    step(); step();

    // Reset state
    check("rst_in_ready", in_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_result_valid", result_valid, 0);
    for (int k = 0; k < 4; k++) check($sformatf("rst_result%0d", k), res[k], 0);
    rstn = 1'b1;
    step();

    // Single beat: hand-computed results
    do_start(1);
    check("single_in_ready_after_start", in_ready, 1);
    set_beat(32'h01020304, 32'h01010101, 32'hFFFFFFFF, 32'h7F7F7F7F, 32'h80808080);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check("single_drain_in_ready", in_ready, 0);
    check("single_drain_rv", result_valid, 0);
    check("single_drain_busy", busy, 1);
    step();
    check("single_rv_two_after_beat", result_valid, 1);
    check("single_result0", res[0], 10);
    check("single_result1", res[1], -10);
    check("single_result2", res[2], 1270);
    check("single_result3", res[3], -1280);
    do_ack();

    // Stalled run
    pattern = '{1, 0, 1, 0, 1};
    do_start(3);
    set_beat(32'h7F7F7F7F, 32'h7F7F7F7F, '0, '0, '0);
    for (int i = 0; i < 5; i++) begin
      in_valid = pattern[i][0];
      step();
    end
    in_valid = 1'b0;
    check("stall_drain_in_ready", in_ready, 0);
    check("stall_beats_consumed", beats, 3);
    step();
    check("stall_rv", result_valid, 1);
    check("stall_done_in_ready", in_ready, 0);
    check("stall_result0", res[0], 193548);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check("stall_no_beat_in_done", beats, 3);
    do_ack();

    // Zero length, hold with ignored start / in_valid
    do_start(0);
    check("zero_rv_after_start", result_valid, 1);
    for (int k = 0; k < 4; k++) check($sformatf("zero_result%0d", k), res[k], 0);
    for (int i = 0; i < 5; i++) begin
      start = 1'b1; len = 9'd7; in_valid = 1'b1;
      step();
    end
    start = 1'b0; in_valid = 1'b0;
    check("zero_hold_rv", result_valid, 1);
    check("zero_hold_no_beats", beats, 0);
    do_ack();

    // Reset mid-run, then a normal run with varied vectors
    do_start(4);
    set_beat(32'h11223344, 32'h01020304, 32'hF0F0F0F0, 32'h7F000080, 32'h00FF0001);
    in_valid = 1'b1;
    step(); step();
    in_valid = 1'b0;
    rstn = 1'b0;
    step();
    rstn = 1'b1;
    model_clear();
    check("midrst_in_ready", in_ready, 0);
    check("midrst_busy", busy, 0);
    check("midrst_rv", result_valid, 0);
    for (int k = 0; k < 4; k++) check($sformatf("midrst_result%0d", k), res[k], 0);
    tab_f = '{32'h80FF017F, 32'h12345678, 32'hFEDCBA98};
    tab_w = '{'{32'h7F7F7F7F, 32'h80808080, 32'h01FF01FF, 32'h00000000},
              '{32'h0A0B0C0D, 32'hF1F2F3F4, 32'h7F80017F, 32'h55AA55AA},
              '{32'h80808080, 32'h01020304, 32'hFFFEFDFC, 32'h40404040}};
    do_start(3);
    for (int i = 0; i < 3; i++) begin
      set_beat(tab_f[i], tab_w[i][0], tab_w[i][1], tab_w[i][2], tab_w[i][3]);
      in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
    wait_rv(4);
    check("table_beats", beats, 3);
    do_ack();

    // Max length, most negative operands
    do_start(511);
    set_beat(32'h80808080, 32'h80808080, '0, '0, '0);
    in_valid = 1'b1;
    for (int i = 0; i < 511; i++) step();
    in_valid = 1'b0;
    check("max_beats", beats, 511);
    wait_rv(4);
`ifndef MAC_ARRAY_SAT_EN
    check("max_result0_wrap", res[0], 33488896);
`endif

    // Ack/start race in DONE
    result_ack = 1'b1; start = 1'b1; len = 9'd2;
    step();
    result_ack = 1'b0; start = 1'b0;
    check("race_idle_busy", busy, 0);
    check("race_idle_rv", result_valid, 0);
    do_start(1);
    check("race_restart_in_ready", in_ready, 1);
    for (int k = 0; k < 4; k++) check($sformatf("race_cleared%0d", k), res[k], 0);
    set_beat(32'h05FB7F80, 32'h03030303, 32'hFDFDFDFD, 32'h80808080, 32'h7F7F7F7F);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    wait_rv(4);
    check("race_beats", beats, 1);
    do_ack();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
